// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    WAIT_CLK,
    SEND,
    ACK,
    WAIT_IDLE,
    ERROR
  } ps2_state_e;

  localparam int TIMER_W = 24;

  localparam logic [1:0] ERR_NONE          = 2'b00;
  localparam logic [1:0] ERR_NO_ACK        = 2'b01;
  localparam logic [1:0] ERR_START_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_FRAME_TIMEOUT = 2'b11;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 pin plus a falling-edge detector.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  output logic level,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift the raw pin through the synchronizer and keep one older sample for edge detection.
  always_comb begin
    meta_d = pin_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Flops reset high because an idle PS/2 line is pulled up; this avoids a false edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q;
  assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter using the request-to-send handshake.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ           = 100_000_000,
  parameter int INHIBIT_US       = 100,
  parameter int START_TIMEOUT_MS = 15,
  parameter int FRAME_TIMEOUT_MS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code
);

  localparam int INHIBIT_CYCLES = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int START_CYCLES   = CLK_HZ / 1000 * START_TIMEOUT_MS;
  localparam int FRAME_CYCLES   = CLK_HZ / 1000 * FRAME_TIMEOUT_MS;

  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_CYCLES - 1);
  localparam logic [TIMER_W-1:0] FRAME_LAST   = TIMER_W'(FRAME_CYCLES - 1);

  logic clk_level, clk_fall;
  logic data_level, data_fall;

  ps2_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d, timer_inc;
  logic [7:0]         shift_q, shift_d;
  logic               parity_q, parity_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic               clk_oe_q, clk_oe_d;
  logic               data_oe_q, data_oe_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               in_frame;

  ps2_sync_edge u_clk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_in (ps2_clk_in),
    .level  (clk_level),
    .fall   (clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_in (ps2_data_in),
    .level  (data_level),
    .fall   (data_fall)
  );

  // Next-state logic; the frame timeout check at the end overrides any edge action in the same cycle.
  always_comb begin
    timer_inc  = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    state_d    = state_q;
    timer_d    = timer_inc;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    in_frame   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          shift_d  = cmd_data;
          parity_d = odd_parity(cmd_data);
          clk_oe_d = 1'b1;
          timer_d  = '0;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (timer_q == INHIBIT_LAST) begin
          data_oe_d = 1'b1;
          clk_oe_d  = 1'b0;
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = WAIT_CLK;
        end
      end
      WAIT_CLK: begin
        if (timer_q == START_LAST) begin
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b0;
          err_code_d = ERR_START_TIMEOUT;
          err_d      = 1'b1;
          state_d    = ERROR;
        end else if (clk_fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = 4'd1;
          timer_d   = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        in_frame = 1'b1;
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q <= 4'd7) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end else if (bit_cnt_q == 4'd8) begin
            data_oe_d = ~parity_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end
        end
      end
      ACK: begin
        in_frame = 1'b1;
        if (clk_fall) begin
          if (!data_level) begin
            state_d = WAIT_IDLE;
          end else begin
            clk_oe_d   = 1'b0;
            data_oe_d  = 1'b0;
            err_code_d = ERR_NO_ACK;
            err_d      = 1'b1;
            state_d    = ERROR;
          end
        end
      end
      WAIT_IDLE: begin
        if (done_q) begin
          state_d = IDLE;
        end else begin
          in_frame = 1'b1;
          if (clk_level && data_level) begin
            done_d = 1'b1;
          end
        end
      end
      ERROR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (in_frame && timer_q == FRAME_LAST) begin
      clk_oe_d   = 1'b0;
      data_oe_d  = 1'b0;
      done_d     = 1'b0;
      err_code_d = ERR_FRAME_TIMEOUT;
      err_d      = 1'b1;
      state_d    = ERROR;
    end
  end

  // All FSM state and registered outputs; reset drops both line drivers immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign tx_busy     = (state_q != IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign err_code    = err_code_q;

  // Falling edges on the data line carry no meaning for the transmitter.
  logic unused_data_fall;
  assign unused_data_fall = data_fall;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed testbench for ps2_host_tx with a simple open-drain PS/2 device model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int CLK_HZ         = 1_000_000;
  localparam int INHIBIT_CYCLES = 100;
  localparam int START_CYCLES   = 15_000;
  localparam int FRAME_CYCLES   = 2_000;
  localparam int HALF           = 10;
  localparam int QTR            = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] err_code;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  int check_cnt = 0;
  int error_cnt = 0;
  int cyc       = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int err_cyc   = 0;
  logic [1:0] err_seen = 2'b00;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ           (CLK_HZ),
    .INHIBIT_US       (100),
    .START_TIMEOUT_MS (15),
    .FRAME_TIMEOUT_MS (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_data    (cmd_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .err_code    (err_code)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Cycle counter used to timestamp pulses and pin edges.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts cycles where done/err are high and captures err_code with each error.
  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) begin
      err_cnt  <= err_cnt + 1;
      err_cyc  <= cyc;
      err_seen <= err_code;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_cnt++;
    if (observed !== expected) begin
      error_cnt++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("ready_before_accept", cmd_ready, 1);
    cmd_data  = cmd;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("clk_oe_one_cycle_after_accept", ps2_clk_oe, 1);
  endtask

  task automatic wait_rts(output int inh, output int rel_cyc, output bit ok);
    int n = 0;
    inh = 0;
    rel_cyc = 0;
    ok = 1'b0;
    while (n < 500) begin
      if (ps2_data_oe && !ps2_clk_oe) begin
        ok = 1'b1;
        rel_cyc = cyc;
        break;
      end
      if (ps2_clk_oe) inh++;
      @(negedge clk);
      n++;
    end
    if (!ok) checkOutput("rts_wait_expired", 0, 1);
  endtask

  task automatic device_run(input int n_clk, input bit do_ack, output logic [10:0] bits,
                            output int fe1_cyc, output int inh, output bit ok);
    int rel;
    bits = '1;
    fe1_cyc = 0;
    wait_rts(inh, rel, ok);
    if (ok) begin
      repeat (HALF) @(negedge clk);
      bits[0] = ps2_data_in;
      for (int i = 1; i <= n_clk && i <= 11; i++) begin
        if (i == 11 && do_ack) begin
          dev_data_low = 1'b1;
          repeat (QTR) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        if (i == 1) fe1_cyc = cyc;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        if (i <= 10) bits[i] = ps2_data_in;
        repeat (HALF) @(negedge clk);
        dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic wait_pulse(input int base, input int budget, output bit got);
    int n = 0;
    while ((done_cnt + err_cnt) == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    got = ((done_cnt + err_cnt) != base);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [10:0] exp_bits, input bit poke_busy,
                           input string name);
    int base_done, base_err, fe1, inh;
    logic [10:0] bits;
    bit ok, got;
    base_done = done_cnt;
    base_err  = err_cnt;
    applyStimulus(cmd);
    if (poke_busy) begin
      cmd_data  = 8'h00;
      cmd_valid = 1'b1;
    end
    device_run(11, 1'b1, bits, fe1, inh, ok);
    cmd_valid = 1'b0;
    checkOutput({name, "_inhibit_len"}, inh, INHIBIT_CYCLES);
    checkOutput({name, "_bits"}, bits, exp_bits);
    wait_pulse(base_done + base_err, 200, got);
    checkOutput({name, "_done_seen"}, got, 1);
    repeat (3) @(negedge clk);
    checkOutput({name, "_done_count"}, done_cnt - base_done, 1);
    checkOutput({name, "_no_err"}, err_cnt - base_err, 0);
    checkOutput({name, "_ready"}, cmd_ready, 1);
    checkOutput({name, "_lines_released"}, {ps2_clk_oe, ps2_data_oe}, 0);
    if (poke_busy) begin
      repeat (20) @(negedge clk);
      checkOutput({name, "_no_queued_cmd"}, tx_busy, 0);
    end
  endtask

  initial begin
    int base, fe1, inh, rel, diff;
    logic [10:0] bits;
    bit ok, got;

    rst_n     = 1'b0;
    cmd_data  = 8'h00;
    cmd_valid = 1'b0;
    #1;
    checkOutput("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    checkOutput("reset_ready", cmd_ready, 1);
    checkOutput("reset_busy", tx_busy, 0);
    checkOutput("reset_pulses", {tx_done, tx_err}, 0);
    checkOutput("reset_err_code", err_code, ERR_NONE);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Normal transfers with ACK; expected = {stop, parity, data, start}
    run_frame(PS2_CMD_SET_LED, 11'h7DA, 1'b0, "ed");
    checkOutput("ed_err_code", err_code, 2'b00);
    run_frame(PS2_CMD_ENABLE, 11'h5E8, 1'b1, "f4");
    run_frame(8'h00, 11'h600, 1'b0, "zero");
    run_frame(PS2_CMD_RESET, 11'h7FE, 1'b0, "ff");

    // Device clocks 11 times but leaves data high on the ACK edge
    base = done_cnt + err_cnt;
    applyStimulus(PS2_CMD_ENABLE);
    device_run(11, 1'b0, bits, fe1, inh, ok);
    wait_pulse(base, 200, got);
    checkOutput("noack_err_seen", got, 1);
    checkOutput("noack_err_code", err_seen, ERR_NO_ACK);
    checkOutput("noack_lines", {ps2_clk_oe, ps2_data_oe}, 0);

    // Device stops clocking after the 5th bit
    base = done_cnt + err_cnt;
    applyStimulus(PS2_CMD_SET_LED);
    device_run(5, 1'b0, bits, fe1, inh, ok);
    wait_pulse(base, FRAME_CYCLES + 200, got);
    checkOutput("frame_to_err_seen", got, 1);
    checkOutput("frame_to_err_code", err_seen, ERR_FRAME_TIMEOUT);
    diff = err_cyc - fe1;
    checkOutput("frame_to_time", (diff >= FRAME_CYCLES - 2 && diff <= FRAME_CYCLES + 8) ? FRAME_CYCLES : diff,
                FRAME_CYCLES);
    checkOutput("frame_to_lines", {ps2_clk_oe, ps2_data_oe}, 0);

    // Device never clocks
    base = done_cnt + err_cnt;
    applyStimulus(PS2_CMD_RESET);
    wait_rts(inh, rel, ok);
    wait_pulse(base, START_CYCLES + 200, got);
    checkOutput("start_to_err_seen", got, 1);
    checkOutput("start_to_err_code", err_seen, ERR_START_TIMEOUT);
    diff = err_cyc - rel;
    checkOutput("start_to_time", (diff >= START_CYCLES - 1 && diff <= START_CYCLES + 1) ? START_CYCLES : diff,
                START_CYCLES);
    checkOutput("start_to_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    repeat (50) @(negedge clk);
    checkOutput("start_to_lines_later", {ps2_clk_oe, ps2_data_oe}, 0);
    checkOutput("start_to_ready", cmd_ready, 1);

    // Reset asserted in the middle of SEND while data is being pulled low
    applyStimulus(8'h00);
    device_run(4, 1'b0, bits, fe1, inh, ok);
    checkOutput("rst_pre_data_oe", ps2_data_oe, 1);
    checkOutput("rst_pre_busy", tx_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    checkOutput("rst_async_busy", tx_busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_after_ready", cmd_ready, 1);
    checkOutput("rst_after_err_code", err_code, ERR_NONE);
    run_frame(PS2_CMD_SET_LED, 11'h7DA, 1'b0, "ed_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), using the PS/2 host request-to-send sequence, and reports whether the device acknowledged it. It sits beside the PS/2 receive path on the same two open-drain lines and drives them only through active-high pull-low enables. The top level holds the receive path off while `tx_busy` is high.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `INHIBIT_US`, 100: how long the host holds PS2Clk low before request-to-send.
- `START_TIMEOUT_MS`, 15: maximum wait from line release to the first device falling edge.
- `FRAME_TIMEOUT_MS`, 2: maximum time from the first device falling edge to ACK completion.
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cmd_data`  in  8: command byte. Sampled when `cmd_valid && cmd_ready`.
- `cmd_valid`  in  1: a command is offered.
- `cmd_ready`  out  1: high only in IDLE.
- `ps2_clk_in`  in  1: raw PS2Clk pin level, asynchronous.
- `ps2_data_in`  in  1: raw PS2Data pin level, asynchronous.
- `ps2_clk_oe`  out  1: 1 = pull PS2Clk low, 0 = release it.
- `ps2_data_oe`  out  1: 1 = pull PS2Data low, 0 = release it.
- `tx_busy`  out  1: high in every state except IDLE.
- `tx_done`  out  1: one-cycle pulse on successful completion.
- `tx_err`  out  1: one-cycle pulse on failure. `err_code` is valid in the same cycle.
- `err_code`  out  2: 01 = no ACK, 10 = start timeout, 11 = frame timeout. Holds its value until the next error.

## Operation
- **Reset values:** `ps2_clk_oe`=0, `ps2_data_oe`=0, `cmd_ready`=1, `tx_busy`=0, `tx_done`=0, `tx_err`=0, `err_code`=00, state IDLE. Asserting reset mid-frame releases both lines immediately (asynchronously).
- **Input conditioning:** both pins pass through a 2-flop synchronizer. A falling edge ("fe") is detected as previous synchronized level 1 and current level 0.
- **Frame:** 11 bits. Start bit is 0, then data LSB first, then odd parity (parity = ~^`cmd_data`), then stop bit 1 (line released).
- **IDLE:** on accept, latch `cmd_data` into a shift register, compute parity, assert `ps2_clk_oe`, clear the timer, go to INHIBIT.
- **INHIBIT:** count INHIBIT_CYCLES = CLK_HZ/1_000_000*INHIBIT_US. At terminal count, set `ps2_data_oe`=1 (start bit), release `ps2_clk_oe`, clear the timer and bit counter, go to WAIT_CLK.
- **WAIT_CLK:** on the first fe, drive d0 (`ps2_data_oe` = ~d0), set bit count to 1, clear the timer, go to SEND.
  - If START_TIMEOUT expires first, release both lines, set `err_code`=10, go to ERROR.
- **SEND:** on each fe, increment the bit count:
  - count 2–8: drive d1..d7.
  - count 9: drive parity.
  - count 10: release data (stop bit), go to ACK.
  - `ps2_data_oe` always equals the inverse of the bit being sent.
- **ACK:** on the next fe, sample synchronized data.
  - Data 0: go to WAIT_IDLE.
  - Data 1: set `err_code`=01, go to ERROR.
- **WAIT_IDLE:** when synchronized clk and data are both 1, pulse `tx_done` and return to IDLE.
- **Frame timeout:** FRAME_TIMEOUT applies across SEND, ACK and WAIT_IDLE. On expiry, release both lines, set `err_code`=11, go to ERROR.
- **ERROR:** one cycle. Pulse `tx_err`, go to IDLE.
- While busy, `cmd_valid` is ignored and no command is queued.
- The timer is 24 bits wide and saturating. Timeout counts are computed from CLK_HZ and the ms parameters at elaboration.

## Timing
- Accept to `ps2_clk_oe` rising: 1 cycle (registered).
- INHIBIT lasts exactly INHIBIT_CYCLES cycles (10 000 at defaults). `ps2_data_oe` rises in the same cycle that `ps2_clk_oe` falls.
- Pin fe to `ps2_data_oe` update: 3 `clk` cycles (2 synchronizer flops plus the registered output). This is well inside the device's ~30–50 µs low half-period.
- `tx_done` rises 1 cycle after both synchronized lines are seen high. `cmd_ready` rises in the cycle after the `tx_done` pulse.
- Back-to-back commands: the next accept can happen no earlier than 1 cycle after `tx_done` or `tx_err`.
- If a device clock fe and a timeout expire in the same cycle, the timeout wins.

## Structure
- Package `ps2_pkg` holds:
  - the state enum (IDLE, INHIBIT, WAIT_CLK, SEND, ACK, WAIT_IDLE, ERROR);
  - the `err_code` constants;
  - command constants PS2_CMD_SET_LED=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF.
- Sub-module `ps2_sync_edge` contains one synchronizer plus the falling-edge detector. Instantiate it twice, once for clk and once for data.

## Test plan
- **Send 0xED, device model ACKs:** PS2Data bits seen at the device's rising edges are 0,1,0,1,1,0,1,1,1,1 then ACK. `tx_done` pulses once and `err_code` stays 00.
- **Send 0xF4:** parity bit is 0. **Send 0x00:** parity bit is 1. **Send 0xFF:** parity bit is 1. In all three cases the start bit is 0 and the stop bit is released.
- **Device never clocks:** `tx_err` pulses at 15 ms ±1 cycle with `err_code`=10. Both oe outputs are 0 from then on.
- **Device clocks 11 times but holds data high at the ACK edge:** `tx_err` pulses with `err_code`=01.
- **Device stops clocking after the 5th bit:** `tx_err` pulses 2 ms after the first fe with `err_code`=11, and both lines are released.
- **`rst_n` asserted during SEND:** both oe outputs drop with no clock edge. After release, `cmd_ready`=1 and a new 0xED transfer completes normally.
